// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: muldiv op encodings, ALU opcodes and the
// multiply/divide sequencer state encodings used by the controller.
package sap_pkg;

  localparam logic MULDIV_OP_MUL = 1'b0;
  localparam logic MULDIV_OP_DIV = 1'b1;

  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;

  localparam logic [0:0] MULDIV_ST_IDLE = 1'b0;
  localparam logic [0:0] MULDIV_ST_RUN  = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer: a shift-add multiply step
// or a restoring-divide step, selected by op.
module muldiv_step
  import sap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 op,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [2*WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   acc_nxt,
  output logic [2*WIDTH-1:0]   opa_nxt,
  output logic [WIDTH-1:0]     opb_nxt
);

  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] diff_s;

  // MUL: acc = product, opa = shifted multiplicand, opb = shifting multiplier.
  // DIV: acc = {remainder, quotient}, opa[WIDTH-1:0] = shifting dividend, opb = divisor.
  always_comb begin
    trial_s = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
    diff_s  = trial_s[WIDTH-1:0] - opb;
    acc_nxt = acc;
    opa_nxt = opa << 1;
    opb_nxt = opb;
    if (op == MULDIV_OP_MUL) begin
      opb_nxt = opb >> 1;
      if (opb[0]) begin
        acc_nxt = acc + opa;
      end else begin
        acc_nxt = acc;
      end
    end else begin
      // trial_s is WIDTH+1 bits so the shifted-out remainder MSB takes part in the compare
      if (trial_s >= {1'b0, opb}) begin
        acc_nxt = {diff_s, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide engine for the SAP-1 datapath:
// one bit per clock, results and flags registered until the next accepted start.
module muldiv_sequencer
  import sap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             ovf,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [0:0]         state_r;
  logic [CW-1:0]      count_r;
  logic               op_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] opa_r;
  logic [WIDTH-1:0]   opb_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   result_r;
  logic [WIDTH-1:0]   result_hi_r;
  logic               ovf_r;
  logic               dbz_r;

  logic [2*WIDTH-1:0] acc_nxt_s;
  logic [2*WIDTH-1:0] opa_nxt_s;
  logic [WIDTH-1:0]   opb_nxt_s;
  logic               div_zero_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_r),
    .acc     (acc_r),
    .opa     (opa_r),
    .opb     (opb_r),
    .acc_nxt (acc_nxt_s),
    .opa_nxt (opa_nxt_s),
    .opb_nxt (opb_nxt_s)
  );

  assign div_zero_s = (op_r == MULDIV_OP_DIV) && (opb_r == {WIDTH{1'b0}});

  // FSM, iteration counter, operand/accumulator registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= MULDIV_ST_IDLE;
      count_r     <= {CW{1'b0}};
      op_r        <= MULDIV_OP_MUL;
      acc_r       <= {(2*WIDTH){1'b0}};
      opa_r       <= {(2*WIDTH){1'b0}};
      opb_r       <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      ovf_r       <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        MULDIV_ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            op_r    <= op;
            opa_r   <= {{WIDTH{1'b0}}, a_in};
            opb_r   <= b_in;
            acc_r   <= {(2*WIDTH){1'b0}};
            count_r <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            dbz_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= MULDIV_ST_RUN;
          end
        end
        MULDIV_ST_RUN: begin
          if (div_zero_s) begin
            // divide by zero short-circuits after one cycle with saturated quotient
            result_r    <= {WIDTH{1'b1}};
            result_hi_r <= opa_r[WIDTH-1:0];
            dbz_r       <= 1'b1;
            ovf_r       <= 1'b0;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= MULDIV_ST_IDLE;
          end else begin
            acc_r   <= acc_nxt_s;
            opa_r   <= opa_nxt_s;
            opb_r   <= opb_nxt_s;
            count_r <= count_r + CNT_ONE;
            if (count_r == CNT_LAST) begin
              result_r    <= acc_nxt_s[WIDTH-1:0];
              result_hi_r <= acc_nxt_s[2*WIDTH-1:WIDTH];
              ovf_r       <= (op_r == MULDIV_OP_MUL) && (acc_nxt_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= MULDIV_ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= MULDIV_ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign result_hi = result_hi_r;
  assign ovf       = ovf_r;
  assign dbz       = dbz_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed, table-driven bench for muldiv_sequencer with hand-computed
// expectations plus sequences for busy-start, start-on-done and mid-op reset.
module tb_muldiv_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       op;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       ovf;
  logic       dbz;

  int checks;
  int failures;

  typedef struct {
    string      name;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] hi;
    logic       ovf;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  muldiv_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, return edges from start edge until done is seen (0 on timeout).
  task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int seen_done;
    checks = 0;
    failures = 0;
    rst = 1'b1; start = 1'b0; op = 1'b0; a_in = 8'd0; b_in = 8'd0;

    vecs[0] = '{"mul_13x11",   1'b0, 8'd13,  8'd11,  8'h8F, 8'h00, 1'b0, 1'b0, 8};
    vecs[1] = '{"mul_255x255", 1'b0, 8'd255, 8'd255, 8'h01, 8'hFE, 1'b1, 1'b0, 8};
    vecs[2] = '{"div_200_7",   1'b1, 8'd200, 8'd7,   8'h1C, 8'h04, 1'b0, 1'b0, 8};
    vecs[3] = '{"div_5_0",     1'b1, 8'd5,   8'd0,   8'hFF, 8'h05, 1'b0, 1'b1, 1};
    vecs[4] = '{"mul_16x16",   1'b0, 8'd16,  8'd16,  8'h00, 8'h01, 1'b1, 1'b0, 8};
    vecs[5] = '{"mul_0x77",    1'b0, 8'd0,   8'd77,  8'h00, 8'h00, 1'b0, 1'b0, 8};
    vecs[6] = '{"div_255_1",   1'b1, 8'd255, 8'd1,   8'hFF, 8'h00, 1'b0, 1'b0, 8};
    vecs[7] = '{"div_7_200",   1'b1, 8'd7,   8'd200, 8'h00, 8'h07, 1'b0, 1'b0, 8};
    vecs[8] = '{"div_0_0",     1'b1, 8'd0,   8'd0,   8'hFF, 8'h00, 1'b0, 1'b1, 1};
    vecs[9] = '{"div_171_10",  1'b1, 8'd171, 8'd10,  8'h11, 8'h01, 1'b0, 1'b0, 8};

    tick(); tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_result_hi", {24'd0, result_hi}, 32'd0);
    check("reset_flags", {30'd0, ovf, dbz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      check({vecs[i].name, "_result"}, {24'd0, result}, {24'd0, vecs[i].res});
      check({vecs[i].name, "_result_hi"}, {24'd0, result_hi}, {24'd0, vecs[i].hi});
      check({vecs[i].name, "_ovf"}, {31'd0, ovf}, {31'd0, vecs[i].ovf});
      check({vecs[i].name, "_dbz"}, {31'd0, dbz}, {31'd0, vecs[i].dbz});
      check({vecs[i].name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      tick();
      check({vecs[i].name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    end

    // Start while busy is ignored; start on the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_in = 8'd3; b_in = 8'd4;
    tick();
    start = 1'b0;
    tick(); tick();
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_in = 8'd9; b_in = 8'd9;
    tick();
    start = 1'b0;
    lat = 3;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      lat++;
    end
    check("busy_start_latency", lat, 8);
    check("busy_start_ignored", {24'd0, result}, 32'd12);
    check("busy_start_hi", {24'd0, result_hi}, 32'd0);
    start = 1'b1; op = 1'b1; a_in = 8'd9; b_in = 8'd2;
    tick();
    start = 1'b0;
    check("start_on_done_busy", {31'd0, busy}, 32'd1);
    check("start_on_done_done", {31'd0, done}, 32'd0);
    check("result_held_while_run", {24'd0, result}, 32'd12);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    check("div_9_2_latency", lat, 8);
    check("div_9_2_result", {24'd0, result}, 32'd4);
    check("div_9_2_rem", {24'd0, result_hi}, 32'd1);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_in = 8'd100; b_in = 8'd3;
    tick();
    start = 1'b0;
    tick(); tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_result", {24'd0, result}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen_done = 1;
    end
    check("rst_mid_no_done", seen_done, 0);
    run_op(1'b0, 8'd2, 8'd2, lat);
    check("mul_2x2_latency", lat, 8);
    check("mul_2x2_result", {24'd0, result}, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
